color_scan_sequencer: RTL
=========================

// Module: color_scan_sequencer
// PURPOSE
//  Sequences a TCS3200-class colour sensor through its red, green and blue filters.
//  Counts sensor output pulses over a fixed gate window for each filter.
//  Presents the three counts as red_norm/green_norm/blue_norm to the downstream
//  colour comparator, with a one-cycle valid strobe per completed scan.
//  Sits between the sensor pins and the colour-identifier datapath.
// PARAMETERS
//  GATE_CYCLES    50000  clk cycles per counting window (1 ms @ 50 MHz); >=1
//  SETTLE_CYCLES  500    clk cycles after a filter change before counting; >=1
//  CNT_W          16     width of pulse counters and *_norm outputs
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst_n       in   1      synchronous reset, active low
//  start       in   1      scan request, sampled each cycle; ignored while busy
//  sensor_out  in   1      sensor frequency output, asynchronous to clk
//  s2          out  1      sensor filter select bit S2
//  s3          out  1      sensor filter select bit S3
//  red_norm    out  CNT_W  last completed red count
//  green_norm  out  CNT_W  last completed green count
//  blue_norm   out  CNT_W  last completed blue count
//  valid       out  1      1-cycle pulse: *_norm updated this cycle
//  busy        out  1      high from accepted start until the DONE cycle, inclusive
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; s2=0; s3=0; *_norm=0; valid=0; busy=0;
//    counters, sync flops and edge register cleared. Any scan in progress is abandoned.
//  - Input path: sensor_out -> 2-flop synchronizer -> 1 delay flop.
//    An edge = sync=1 and delay=0, i.e. a 1-cycle pulse 3 cycles after the pin edge.
//  - Filter encoding {s2,s3}: RED=00, BLUE=01, GREEN=11.
//    Select is driven registered, from the state register.
//  - FSM states: IDLE, SETTLE, COUNT, STORE, DONE. Channel index ch cycles R->G->B.
//  - IDLE:
//      start=1 -> SETTLE with ch=R, {s2,s3}=00, busy=1, timer=0.
//  - SETTLE:
//      lasts exactly SETTLE_CYCLES cycles; edges are ignored; then -> COUNT, count=0.
//  - COUNT:
//      lasts exactly GATE_CYCLES cycles; each edge pulse increments count;
//      count saturates at 2^CNT_W-1 (no wrap); then -> STORE.
//  - STORE (1 cycle): count latched into the shadow register for ch.
//      ch=R -> ch=G, {s2,s3}=11, go to SETTLE.
//      ch=G -> ch=B, {s2,s3}=01, go to SETTLE.
//      ch=B -> DONE.
//  - DONE (1 cycle): all three shadow registers copied to *_norm simultaneously;
//    valid=1; next IDLE with busy=0 and {s2,s3}=00.
//    *_norm never shows a partial scan.
//  - Scan latency from start-accept cycle to valid: 3*(SETTLE_CYCLES+GATE_CYCLES+1)+1 cycles.
//  - start while busy: ignored, not queued.
//    start asserted in the DONE cycle: ignored.
//    start in the following IDLE cycle: accepted.
//  - Edge coinciding with the SETTLE->COUNT transition cycle: not counted.
//    Edge in the final COUNT cycle: counted.
//  - *_norm hold their value indefinitely between scans.
// CONFIGURATION
//  - COLOR_SCAN_AUTO_EN defined:
//    IDLE starts a new scan automatically every cycle it is entered (start is ignored).
//    Result: back-to-back scans, busy low for exactly 1 cycle between scans.
//  - Not defined: scans only on start; block rests in IDLE.
// TESTING  (GATE_CYCLES=100, SETTLE_CYCLES=10, CNT_W=16)
//  - Reset, then hold rst_n=1 with start=0 for 50 cycles.
//    -> all outputs 0; s2=s3=0; busy=0; no valid.
//  - start pulse; sensor_out square wave, period 10 clk in all channels.
//    -> valid exactly 334 cycles after accept.
//    -> red_norm=green_norm=blue_norm=10 (+/-1).
//    -> {s2,s3} sequence 00,11,01 then 00.
//  - Per-channel periods R=4, G=20, B=50 clk.
//    -> red_norm=25, green_norm=5, blue_norm=2 (+/-1).
//  - Pulse start repeatedly mid-scan.
//    -> single valid only; busy stays 1 throughout; no restart.
//  - Assert rst_n=0 for 1 cycle during the GREEN COUNT state.
//    -> next cycle busy=0, *_norm=0, s2=s3=0; no valid.
//  - CNT_W=4; sensor period 2 clk.
//    -> all counts saturate at 15.
//  - With COLOR_SCAN_AUTO_EN and start held 0:
//    -> valid every 335 cycles; busy low for exactly 1 cycle between scans.

Source files
------------

// File: rtl/color_scan_sequencer_if.sv
// ============================================================================
// color_scan_sequencer_if : sensor pins, scan request and result bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface color_scan_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             sensor_out;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] red_norm;
    logic [CNT_W-1:0] green_norm;
    logic [CNT_W-1:0] blue_norm;
    logic             valid;
    logic             busy;

    modport master (
        output start,
        output sensor_out,
        input  s2,
        input  s3,
        input  red_norm,
        input  green_norm,
        input  blue_norm,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  sensor_out,
        output s2,
        output s3,
        output red_norm,
        output green_norm,
        output blue_norm,
        output valid,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/color_scan_sequencer.sv
// ============================================================================
// color_scan_sequencer : R/G/B filter sequencing and gated pulse counting for
// a TCS3200-class sensor. Macro COLOR_SCAN_AUTO_EN enables back-to-back scans.
// Rev 1.0
// ============================================================================
`default_nettype none

module color_scan_sequencer #(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 500,
    parameter int CNT_W         = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    color_scan_sequencer_if.slave bus
);

    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_BLUE  = 2'b01;
    localparam logic [1:0] SEL_GREEN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_t;

    state_t           state_q, state_d;
    ch_t              ch_q, ch_d;
    logic [1:0]       sel_q, sel_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] red_sh_q, red_sh_d;
    logic [CNT_W-1:0] green_sh_q, green_sh_d;
    logic [CNT_W-1:0] red_norm_q, red_norm_d;
    logic [CNT_W-1:0] green_norm_q, green_norm_d;
    logic [CNT_W-1:0] blue_norm_q, blue_norm_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             sync1_q, sync2_q, dly_q;

    logic             w_start;
    logic             w_edge;

`ifdef COLOR_SCAN_AUTO_EN
    assign w_start = 1'b1;
`else
    assign w_start = bus.start;
`endif

    assign w_edge = sync2_q & ~dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= CH_R;
            sel_q        <= SEL_RED;
            timer_q      <= '0;
            count_q      <= '0;
            red_sh_q     <= '0;
            green_sh_q   <= '0;
            red_norm_q   <= '0;
            green_norm_q <= '0;
            blue_norm_q  <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dly_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            sel_q        <= sel_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            red_sh_q     <= red_sh_d;
            green_sh_q   <= green_sh_d;
            red_norm_q   <= red_norm_d;
            green_norm_q <= green_norm_d;
            blue_norm_q  <= blue_norm_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            sync1_q      <= bus.sensor_out;
            sync2_q      <= sync1_q;
            dly_q        <= sync2_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        sel_d        = sel_q;
        timer_d      = timer_q;
        count_d      = count_q;
        red_sh_d     = red_sh_q;
        green_sh_d   = green_sh_q;
        red_norm_d   = red_norm_q;
        green_norm_d = green_norm_q;
        blue_norm_d  = blue_norm_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_SETTLE;
                    ch_d    = CH_R;
                    sel_d   = SEL_RED;
                    busy_d  = 1'b1;
                    timer_d = '0;
                end
            end
            ST_SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = ST_COUNT;
                    timer_d = '0;
                    count_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_COUNT: begin
                if (w_edge && (count_q != CNT_MAX)) begin
                    count_d = count_q + 1'b1;
                end
                if (timer_q == GATE_LAST) begin
                    state_d = ST_STORE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STORE: begin
                case (ch_q)
                    CH_R: begin
                        red_sh_d = count_q;
                        ch_d     = CH_G;
                        sel_d    = SEL_GREEN;
                        state_d  = ST_SETTLE;
                    end
                    CH_G: begin
                        green_sh_d = count_q;
                        ch_d       = CH_B;
                        sel_d      = SEL_BLUE;
                        state_d    = ST_SETTLE;
                    end
                    default: begin
                        // Blue goes straight to the output so all three results appear together in DONE
                        red_norm_d   = red_sh_q;
                        green_norm_d = green_sh_q;
                        blue_norm_d  = count_q;
                        valid_d      = 1'b1;
                        state_d      = ST_DONE;
                    end
                endcase
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sel_d   = SEL_RED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.s2         = sel_q[1];
    assign bus.s3         = sel_q[0];
    assign bus.red_norm   = red_norm_q;
    assign bus.green_norm = green_norm_q;
    assign bus.blue_norm  = blue_norm_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;

endmodule

`default_nettype wire
